// File: rtl/gated_sr_nor_latch.sv
// Clocked model of a gated NOR SR latch. SET, CLR and FORBID are encoded directly as {q, q_}.
// Optional macro GATED_SR_NOR_LATCH_INVALID_FLAG_EN adds a registered 'invalid' output that flags FORBID.
module gated_sr_nor_latch #(
  parameter logic RESET_Q = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic en,
  output logic q,
  output logic q_
`ifdef GATED_SR_NOR_LATCH_INVALID_FLAG_EN
  ,
  output logic invalid
`endif
);

  typedef enum logic [1:0] {
    FORBID = 2'b00,
    CLR    = 2'b01,
    SET    = 2'b10
  } state_t;

  localparam state_t RESET_STATE = RESET_Q ? SET : CLR;

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // A hold request while in FORBID resolves reset-dominant, so the latch drops to CLR.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case ({s, r})
        2'b10:   state_d = SET;
        2'b01:   state_d = CLR;
        2'b11:   state_d = FORBID;
        default: state_d = (state_q == FORBID) ? CLR : state_q;
      endcase
    end
  end

  assign q  = state_q[1];
  assign q_ = state_q[0];

`ifdef GATED_SR_NOR_LATCH_INVALID_FLAG_EN
  logic invalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      invalid_q <= 1'b0;
    end else begin
      invalid_q <= (state_d == FORBID);
    end
  end

  assign invalid = invalid_q;
`endif

endmodule

// File: tb/tb_gated_sr_nor_latch.sv
// Directed self-checking bench for gated_sr_nor_latch with RESET_Q=0.
// Checks of 'invalid' are included when GATED_SR_NOR_LATCH_INVALID_FLAG_EN is defined.
module tb_gated_sr_nor_latch;

  logic clk;
  logic rst;
  logic s;
  logic r;
  logic en;
  logic q;
  logic q_;
`ifdef GATED_SR_NOR_LATCH_INVALID_FLAG_EN
  logic invalid;
`endif

  int total;
  int bad;

  gated_sr_nor_latch #(.RESET_Q(1'b0)) dut (
    .clk(clk),
    .rst(rst),
    .s(s),
    .r(r),
    .en(en),
    .q(q),
    .q_(q_)
`ifdef GATED_SR_NOR_LATCH_INVALID_FLAG_EN
    ,
    .invalid(invalid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst_v, input logic en_v,
                               input logic s_v, input logic r_v);
    rst = rst_v;
    en  = en_v;
    s   = s_v;
    r   = r_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic exp_q,
                             input logic exp_qn, input logic exp_inv);
    total++;
    assert (q === exp_q) else begin
      bad++;
      $error("[TB] FAIL %s.q: observed=%b expected=%b", tag, q, exp_q);
    end
    total++;
    assert (q_ === exp_qn) else begin
      bad++;
      $error("[TB] FAIL %s.q_: observed=%b expected=%b", tag, q_, exp_qn);
    end
`ifdef GATED_SR_NOR_LATCH_INVALID_FLAG_EN
    total++;
    assert (invalid === exp_inv) else begin
      bad++;
      $error("[TB] FAIL %s.invalid: observed=%b expected=%b", tag, invalid, exp_inv);
    end
`else
    if (exp_inv !== 1'b0 && exp_inv !== 1'b1) $display("[TB] note: %s has no flag value", tag);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; en = 1'b0; s = 1'b0; r = 1'b0;

    applyStimulus(1, 0, 0, 0); checkOutput("reset",        0, 1, 0);
    applyStimulus(0, 1, 0, 0); checkOutput("hold_after_rst0", 0, 1, 0);
    applyStimulus(0, 1, 0, 0); checkOutput("hold_after_rst1", 0, 1, 0);

    applyStimulus(0, 1, 0, 1); checkOutput("clr",          0, 1, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("set",          1, 0, 0);
    applyStimulus(0, 1, 0, 0); checkOutput("hold_set",     1, 0, 0);

    applyStimulus(0, 1, 1, 1); checkOutput("forbid",       0, 0, 1);
    applyStimulus(0, 1, 0, 0); checkOutput("forbid_resolve", 0, 1, 0);

    applyStimulus(0, 1, 1, 1); checkOutput("forbid_again", 0, 0, 1);
    applyStimulus(0, 0, 0, 0); checkOutput("frozen_00a",   0, 0, 1);
    applyStimulus(0, 0, 0, 1); checkOutput("frozen_01",    0, 0, 1);
    applyStimulus(0, 0, 1, 0); checkOutput("frozen_10",    0, 0, 1);
    applyStimulus(0, 0, 0, 0); checkOutput("frozen_00b",   0, 0, 1);
    applyStimulus(0, 0, 1, 1); checkOutput("frozen_11",    0, 0, 1);

    applyStimulus(0, 1, 1, 0); checkOutput("forbid_to_set", 1, 0, 0);
    applyStimulus(0, 1, 1, 1); checkOutput("forbid_third", 0, 0, 1);
    applyStimulus(0, 1, 0, 1); checkOutput("forbid_to_clr", 0, 1, 0);

    applyStimulus(0, 1, 1, 0); checkOutput("set_again",    1, 0, 0);
    applyStimulus(0, 0, 0, 1); checkOutput("gated_clr_req", 1, 0, 0);
    applyStimulus(0, 1, 0, 1); checkOutput("en_rise_clr",  0, 1, 0);

    applyStimulus(0, 1, 1, 1); checkOutput("forbid_pre_rst", 0, 0, 1);
    applyStimulus(1, 1, 1, 1); checkOutput("rst_in_forbid", 0, 1, 0);
    applyStimulus(0, 1, 1, 0); checkOutput("first_after_rst", 1, 0, 0);
    applyStimulus(1, 1, 1, 0); checkOutput("rst_over_set", 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
